ad9866_spi_responder: RTL and testbench
=======================================

// Module: ad9866_spi_responder
// PURPOSE
//  SPI target model of the AD9866 4-wire configuration port. It is the far end of the
//   FPGA's AD9866 SPI initiator and is used in simulation and loopback builds.
//  It oversamples sclk/sen_n/sdio in its own clk domain and decodes 16-bit frames.
//  It holds a NUM_REGS x 8 register file, answers read frames on sdo, and exposes
//   write strobes plus decoded RX/TX gain fields to the rest of the design.
// PARAMETERS
//  NUM_REGS      20   number of implemented registers (addresses 0..NUM_REGS-1)
//  SYNC_STAGES   2    synchronizer depth on sclk, sen_n and sdio (>=2)
//  RX_GAIN_ADDR  5'h09  register whose [5:0] drives rx_gain
//  TX_GAIN_ADDR  5'h0a  register whose [5:0] drives tx_gain
// PORTS
//  clk        in   1  oversampling clock; must be >=4x sclk rate (sclk high and low >=2 clk each)
//  reset      in   1  asynchronous, active-high
//  sclk       in   1  SPI clock from initiator; idles low
//  sen_n      in   1  SPI enable, active-low frame delimiter
//  sdio       in   1  serial data in, MSB first, sampled on sclk rising edge
//  sdo        out  1  serial read data, updated after sclk falling edge
//  wr_stb     out  1  one-clk pulse when a write frame commits
//  wr_addr    out  5  address of committed write (held until next commit)
//  wr_data    out  8  data of committed write (held until next commit)
//  rx_gain    out  6  reg[RX_GAIN_ADDR][5:0]
//  tx_gain    out  6  reg[TX_GAIN_ADDR][5:0]
//  frame_err  out  1  one-clk pulse when sen_n rises with 1..15 bits received
// BEHAVIOUR
//  Reset values: sdo=0, wr_stb=0, wr_addr=0, wr_data=0, frame_err=0, all registers 8'h00,
//   so rx_gain=tx_gain=0. State is IDLE and the bit counter is 0.
//  Frame format (16 bits, MSB first):
//   bit15 = R/W (1=read), bits14:13 = ignored, bits12:8 = addr, bits7:0 = data.
//  Edges: the synchronized sclk is compared with its previous value to give rise/fall
//   pulses of one clk each. Edges are honoured only while the synchronized sen_n is 0.
//  FSM:
//   IDLE  -> INSTR   on sync sen_n falling. Clear the shift register and bit count; sdo=0.
//   INSTR : shift sync sdio in on each rise and drive sdo=0.
//           On the 8th rise, latch rw and addr, then go to DATA.
//           If rw=1, drive sdo = rdata[7] in that same clk (before the 9th rise).
//           rdata = reg[addr], or 8'h00 when addr >= NUM_REGS.
//   DATA  : shift sdio in on each rise.
//           If rw=1, each fall after the 9th rise shifts sdo to the next lower bit, so
//             bit k is stable across the high phase of rise 16-k.
//           On the 16th rise with rw=0 and addr < NUM_REGS: write reg[addr] <= data one clk
//             later, and at the same time load wr_addr/wr_data and pulse wr_stb.
//           Writes to addr >= NUM_REGS are dropped: no wr_stb, no register change.
//           After the 16th rise -> DONE.
//   DONE  : ignore further edges and keep sdo=0 after the next fall. Return to IDLE on sen_n rising.
//  sen_n rising in INSTR or DATA (1..15 bits): abort the frame, no write, pulse frame_err,
//   sdo=0, go to IDLE. sen_n rising with 0 bits: no error, go to IDLE.
//  A read frame never modifies registers. The data bits received during a read are ignored.
//  rx_gain/tx_gain update in the same clk as the register write (combinational from the
//   register file).
//  Async reset mid-frame: return immediately to the reset state. The partial frame is
//   discarded and the next sen_n falling starts cleanly.
//  Latency: from the 16th sclk rise at the pins to wr_stb is SYNC_STAGES+2 clk.
// TESTING
//  1 Write 0x0949 (addr 9, data 0x49) -> one wr_stb, wr_addr=09, wr_data=49, rx_gain=6'h09,
//    and reg9 reads back 0x49.
//  2 Write 0x0a3f, then read frame 0x8a00 -> sdo bits 9..16 = 0x3f and tx_gain=6'h3f;
//    no wr_stb is generated by the read.
//  3 Back-to-back writes addr 0..19 (data = addr^0x5a) with sen_n high 2 clk between
//    frames -> 20 wr_stb pulses and a readback of every address matches.
//  4 sen_n raised after 10 bits of 0x0712 -> frame_err pulse, no wr_stb, reg7 stays 0x00;
//    the next full frame 0x0721 writes 0x21.
//  5 Write to addr 0x15 (>= NUM_REGS) -> no wr_stb; a read of 0x15 returns 0x00.
//  6 reset asserted during bit 12 of a write -> all outputs at reset values;
//    a subsequent full write commits normally.

Source files
------------

// File: rtl/ad9866_spi_responder_if.sv
// AD9866 4-wire SPI configuration bus: initiator drives clock, enable and data,
// the target answers on sdo.
interface ad9866_spi_responder_if;
   logic sclk;
   logic sen_n;
   logic sdio;
   logic sdo;

   modport master (output sclk, output sen_n, output sdio, input sdo);
   modport slave  (input sclk, input sen_n, input sdio, output sdo);
endinterface

// File: rtl/ad9866_spi_responder.sv
// AD9866 SPI target model: oversamples the SPI pins, decodes 16-bit frames,
// holds the configuration register file and answers read frames on sdo.
//
//   state | meaning
//   IDLE  | sen_n high, waiting for a frame to start
//   INSTR | shifting the 8 instruction bits (rw, addr)
//   DATA  | shifting the 8 data bits; driving read data on sdo for reads
//   DONE  | 16 bits received, ignoring edges until sen_n rises
module ad9866_spi_responder #(
   parameter int         NUM_REGS     = 20,
   parameter int         SYNC_STAGES  = 2,
   parameter logic [4:0] RX_GAIN_ADDR = 5'h09,
   parameter logic [4:0] TX_GAIN_ADDR = 5'h0a
) (
   input  logic                           clk,
   input  logic                           reset,
   ad9866_spi_responder_if.slave          spi,
   output logic                           wr_stb,
   output logic [4:0]                     wr_addr,
   output logic [7:0]                     wr_data,
   output logic [5:0]                     rx_gain,
   output logic [5:0]                     tx_gain,
   output logic                           frame_err
);

   localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] sen_sync;
   logic [SYNC_STAGES-1:0] sdio_sync;
   logic                   sclk_prev;
   logic                   sen_prev;
   logic [4:0]             bit_cnt;
   logic [6:0]             shift;
   logic [6:0]             rd_sh;
   logic                   rw;
   logic [4:0]             addr;
   logic                   wr_pend;
   logic [7:0]             pend_data;
   logic [7:0]             regs [NUM_REGS];

   logic       sclk_s, sen_s, sdio_s;
   logic       sclk_rise, sclk_fall, sen_fall, sen_rise;
   logic [7:0] shift_nx;
   logic [7:0] instr_rdata;
   logic       addr_ok;

   // Synchronize the SPI pins into clk; sen_n idles high so its chain resets to 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         sen_sync  <= '1;
         sdio_sync <= '0;
         sclk_prev <= 1'b0;
         sen_prev  <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         sen_sync  <= {sen_sync[SYNC_STAGES-2:0], spi.sen_n};
         sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], spi.sdio};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         sen_prev  <= sen_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign sen_s     = sen_sync[SYNC_STAGES-1];
   assign sdio_s    = sdio_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev & ~sen_s;
   assign sclk_fall = ~sclk_s & sclk_prev & ~sen_s;
   assign sen_fall  = sen_prev & ~sen_s;
   assign sen_rise  = ~sen_prev & sen_s;
   assign shift_nx  = {shift, sdio_s};
   assign addr_ok   = ({1'b0, addr} < NUM_REGS_W);

   // Read data for the address completing on the 8th rise; unimplemented addresses read 0.
   always_comb begin
      instr_rdata = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (shift_nx[4:0] == 5'(i)) instr_rdata = regs[i];
      end
   end

   // Frame decoder: bit counting, instruction latch, sdo serialization, write request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         rd_sh     <= '0;
         rw        <= 1'b0;
         addr      <= '0;
         spi.sdo   <= 1'b0;
         frame_err <= 1'b0;
         wr_pend   <= 1'b0;
         pend_data <= '0;
      end else begin
         frame_err <= 1'b0;
         wr_pend   <= 1'b0;
         case (state)
            IDLE: begin
               spi.sdo <= 1'b0;
               if (sen_fall) begin
                  state   <= INSTR;
                  bit_cnt <= '0;
                  shift   <= '0;
               end
            end
            INSTR: begin
               if (sen_rise) begin
                  state     <= IDLE;
                  spi.sdo   <= 1'b0;
                  frame_err <= (bit_cnt != 5'd0);
               end else if (sclk_rise) begin
                  shift   <= shift_nx[6:0];
                  bit_cnt <= bit_cnt + 5'd1;
                  spi.sdo <= 1'b0;
                  if (bit_cnt == 5'd7) begin
                     state <= DATA;
                     rw    <= shift_nx[7];
                     addr  <= shift_nx[4:0];
                     if (shift_nx[7]) begin
                        spi.sdo <= instr_rdata[7];
                        rd_sh   <= instr_rdata[6:0];
                     end
                  end
               end
            end
            DATA: begin
               if (sen_rise) begin
                  state     <= IDLE;
                  spi.sdo   <= 1'b0;
                  frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  shift   <= shift_nx[6:0];
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd15) begin
                     state     <= DONE;
                     wr_pend   <= ~rw & addr_ok;
                     pend_data <= shift_nx;
                  end
               end else if (sclk_fall && rw && bit_cnt >= 5'd9) begin
                  spi.sdo <= rd_sh[6];
                  rd_sh   <= {rd_sh[5:0], 1'b0};
               end
            end
            DONE: begin
               if (sen_rise) begin
                  state   <= IDLE;
                  spi.sdo <= 1'b0;
               end else if (sclk_fall) begin
                  spi.sdo <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Commit a pending write one clk after the 16th rise, together with the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
         wr_stb  <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_stb <= wr_pend;
         if (wr_pend) begin
            wr_addr <= addr;
            wr_data <= pend_data;
         end
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_pend && addr == 5'(i)) regs[i] <= pend_data;
         end
      end
   end

   assign rx_gain = regs[RX_GAIN_ADDR][5:0];
   assign tx_gain = regs[TX_GAIN_ADDR][5:0];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed bench for the AD9866 SPI target model.
module tb_ad9866_spi_responder;

   logic       clk;
   logic       reset;
   logic       wr_stb;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic [5:0] rx_gain;
   logic [5:0] tx_gain;
   logic       frame_err;

   ad9866_spi_responder_if spi_bus ();

   ad9866_spi_responder dut (
      .clk       (clk),
      .reset     (reset),
      .spi       (spi_bus.slave),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rx_gain   (rx_gain),
      .tx_gain   (tx_gain),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int err_cnt = 0;
   int cyc_rise = 0;
   int cyc_stb = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_stb) begin
         wr_cnt++;
         cyc_stb = cyc;
      end
      if (frame_err) err_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic spi_xfer(input logic [15:0] w, input int nbits, input int gap,
                           input bit close, output logic [7:0] rd);
      rd = 8'h00;
      spi_bus.sen_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_bus.sdio = w[15-i];
         repeat (4) @(negedge clk);
         spi_bus.sclk = 1'b1;
         if (i == 15) cyc_rise = cyc;
         repeat (4) @(negedge clk);
         if (i >= 8) rd = {rd[6:0], spi_bus.sdo};
         spi_bus.sclk = 1'b0;
      end
      if (close) begin
         repeat (4) @(negedge clk);
         spi_bus.sen_n = 1'b1;
         repeat (gap) @(negedge clk);
      end
   endtask

   typedef struct {
      logic [15:0] word;
      bit          exp_wr;
      logic [7:0]  exp_rd;
      logic [5:0]  exp_rx;
      logic [5:0]  exp_tx;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [7:0] rd;
      int         w0;
      int         e0;

      vecs[0]  = '{16'h0949, 1'b1, 8'h00, 6'h09, 6'h00};
      vecs[1]  = '{16'h8900, 1'b0, 8'h49, 6'h09, 6'h00};
      vecs[2]  = '{16'h0a3f, 1'b1, 8'h00, 6'h09, 6'h3f};
      vecs[3]  = '{16'h8a00, 1'b0, 8'h3f, 6'h09, 6'h3f};
      vecs[4]  = '{16'h1577, 1'b0, 8'h00, 6'h09, 6'h3f};
      vecs[5]  = '{16'h9500, 1'b0, 8'h00, 6'h09, 6'h3f};
      vecs[6]  = '{16'he9ff, 1'b0, 8'h49, 6'h09, 6'h3f};
      vecs[7]  = '{16'h6a11, 1'b1, 8'h00, 6'h09, 6'h11};
      vecs[8]  = '{16'h8a00, 1'b0, 8'h11, 6'h09, 6'h11};
      vecs[9]  = '{16'h09ff, 1'b1, 8'h00, 6'h3f, 6'h11};
      vecs[10] = '{16'h8900, 1'b0, 8'hff, 6'h3f, 6'h11};

      reset         = 1'b1;
      spi_bus.sclk  = 1'b0;
      spi_bus.sen_n = 1'b1;
      spi_bus.sdio  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset sdo", 32'(spi_bus.sdo), 0);
      chk("reset wr_stb", 32'(wr_stb), 0);
      chk("reset wr_addr", 32'(wr_addr), 0);
      chk("reset wr_data", 32'(wr_data), 0);
      chk("reset frame_err", 32'(frame_err), 0);
      chk("reset rx_gain", 32'(rx_gain), 0);
      chk("reset tx_gain", 32'(tx_gain), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Single writes and reads, including ignored bits and out-of-range addresses.
      for (int v = 0; v < 11; v++) begin
         w0 = wr_cnt;
         spi_xfer(vecs[v].word, 16, 8, 1'b1, rd);
         chk($sformatf("vec%0d wr_stb count", v), 32'(wr_cnt - w0), 32'(vecs[v].exp_wr));
         if (vecs[v].word[15]) chk($sformatf("vec%0d read data", v), 32'(rd), 32'(vecs[v].exp_rd));
         if (vecs[v].exp_wr) begin
            chk($sformatf("vec%0d wr_addr", v), 32'(wr_addr), 32'(vecs[v].word[12:8]));
            chk($sformatf("vec%0d wr_data", v), 32'(wr_data), 32'(vecs[v].word[7:0]));
         end
         chk($sformatf("vec%0d rx_gain", v), 32'(rx_gain), 32'(vecs[v].exp_rx));
         chk($sformatf("vec%0d tx_gain", v), 32'(tx_gain), 32'(vecs[v].exp_tx));
      end

      // Aborted frame after 10 bits, then a clean write to the same register.
      w0 = wr_cnt;
      e0 = err_cnt;
      spi_xfer(16'h0712, 10, 8, 1'b1, rd);
      chk("abort frame_err count", 32'(err_cnt - e0), 1);
      chk("abort wr_stb count", 32'(wr_cnt - w0), 0);
      spi_xfer(16'h8700, 16, 8, 1'b1, rd);
      chk("abort reg7 unchanged", 32'(rd), 32'h00);
      spi_xfer(16'h0721, 16, 8, 1'b1, rd);
      chk("after abort wr_stb count", 32'(wr_cnt - w0), 1);
      spi_xfer(16'h8700, 16, 8, 1'b1, rd);
      chk("after abort reg7", 32'(rd), 32'h21);

      // Back-to-back writes to every register with a 2-clk sen_n gap, then readback.
      w0 = wr_cnt;
      for (int a = 0; a < 20; a++) begin
         spi_xfer({3'b000, 5'(a), 8'(a) ^ 8'h5a}, 16, 2, 1'b1, rd);
      end
      repeat (8) @(negedge clk);
      chk("b2b wr_stb count", 32'(wr_cnt - w0), 20);
      for (int a = 0; a < 20; a++) begin
         spi_xfer({3'b100, 5'(a), 8'h00}, 16, 4, 1'b1, rd);
         chk($sformatf("b2b readback %0d", a), 32'(rd), 32'(8'(a) ^ 8'h5a));
      end
      chk("b2b rx_gain", 32'(rx_gain), 32'h13);
      chk("b2b tx_gain", 32'(tx_gain), 32'h10);

      // Reset during bit 12 of a write.
      w0 = wr_cnt;
      spi_xfer(16'h0b77, 11, 0, 1'b0, rd);
      spi_bus.sdio = 1'b0;
      repeat (4) @(negedge clk);
      spi_bus.sclk = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset sdo", 32'(spi_bus.sdo), 0);
      chk("midreset wr_stb", 32'(wr_stb), 0);
      chk("midreset wr_addr", 32'(wr_addr), 0);
      chk("midreset wr_data", 32'(wr_data), 0);
      chk("midreset frame_err", 32'(frame_err), 0);
      chk("midreset rx_gain", 32'(rx_gain), 0);
      chk("midreset tx_gain", 32'(tx_gain), 0);
      spi_bus.sclk  = 1'b0;
      spi_bus.sen_n = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("midreset no wr_stb", 32'(wr_cnt - w0), 0);
      spi_xfer(16'h0a55, 16, 8, 1'b1, rd);
      chk("post-reset wr_stb count", 32'(wr_cnt - w0), 1);
      chk("wr_stb latency", 32'(cyc_stb - cyc_rise), 4);
      chk("post-reset wr_addr", 32'(wr_addr), 32'h0a);
      chk("post-reset wr_data", 32'(wr_data), 32'h55);
      chk("post-reset tx_gain", 32'(tx_gain), 32'h15);
      spi_xfer(16'h8a00, 16, 8, 1'b1, rd);
      chk("post-reset read reg10", 32'(rd), 32'h55);
      spi_xfer(16'h8b00, 16, 8, 1'b1, rd);
      chk("post-reset read reg11", 32'(rd), 32'h00);
      chk("total frame_err count", 32'(err_cnt), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
